gray_input_qualifier: RTL and testbench

//  Front end for an absolute Gray-coded position input (rotary/linear encoder,
//  4-bit Gray by default). Synchronises the asynchronous input bus and debounces
//  it. Checks that each accepted change obeys the Gray single-bit-step rule.

---
 rtl/gray_input_qualifier.sv | 128 ++++++++++++
 tb/tb_gray_input_qualifier.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/gray_input_qualifier.sv
// Gray-coded position input front end: per-bit synchroniser, stability
// qualifier and acceptance FSM that flags non-single-step code changes.

module gray_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

module gray_input_qualifier #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] gray_out,
  output logic             valid,
  output logic             jump_err,
  output logic             locked
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {ACQ, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s, cand, acc_val, diff, gray_d;
  logic [CW-1:0]    cnt;
  logic             stable, multi, valid_d, jerr_d, locked_d;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sync
      gray_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gray_in[gi]),
        .q   (s[gi])
      );
    end
  endgenerate

  // Candidate tracks the synchronised code; cnt saturates so a long-held
  // value hits the acceptance point exactly once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= '0;
      cnt  <= '0;
    end else if (s != cand) begin
      cand <= s;
      cnt  <= CW'(1);
    end else if (cnt != CW'(STABLE_CYCLES)) begin
      cnt  <= cnt + CW'(1);
    end
  end

  always_comb begin
    stable  = 1'b0;
    acc_val = cand;
    if (STABLE_CYCLES == 1) begin
      // No hold requirement: take the synchronised code directly.
      stable  = 1'b1;
      acc_val = s;
    end else begin
      stable  = (s == cand) && (cnt == CW'(STABLE_CYCLES - 1));
      acc_val = cand;
    end
  end

  // More than one bit differs iff clearing the lowest set bit leaves any.
  assign diff  = acc_val ^ gray_out;
  assign multi = |(diff & (diff - WIDTH'(1)));

  always_comb begin
    state_d  = state_q;
    gray_d   = gray_out;
    valid_d  = 1'b0;
    jerr_d   = 1'b0;
    locked_d = locked;
    case (state_q)
      ACQ: begin
        if (stable) begin
          gray_d   = acc_val;
          valid_d  = 1'b1;
          locked_d = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (stable && (acc_val != gray_out)) begin
          gray_d  = acc_val;
          valid_d = 1'b1;
          jerr_d  = multi;
        end
      end
      default: state_d = ACQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACQ;
      gray_out <= '0;
      valid    <= 1'b0;
      jump_err <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gray_out <= gray_d;
      valid    <= valid_d;
      jump_err <= jerr_d;
      locked   <= locked_d;
    end
  end
endmodule

// File: tb/tb_gray_input_qualifier.sv
// Directed bench for gray_input_qualifier at default parameters.

module tb_gray_input_qualifier;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] gray_in = 4'b1011;
  logic [3:0] gray_out;
  logic       valid, jump_err, locked;
  int         ncmp = 0;
  int         nerr = 0;
  int         n, p;

  gray_input_qualifier dut (
    .clk      (clk),
    .rst      (rst),
    .gray_in  (gray_in),
    .gray_out (gray_out),
    .valid    (valid),
    .jump_err (jump_err),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until valid is seen; n is the edge count after the input change.
  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!valid && cnt < 40);
  endtask

  task automatic quiet(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      tick();
      if (valid || jump_err) pulses++;
    end
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_gray"},   32'(gray_out), 32'h0);
    chk({tag, "_valid"},  32'(valid),    32'h0);
    chk({tag, "_jerr"},   32'(jump_err), 32'h0);
    chk({tag, "_locked"}, 32'(locked),   32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_clear("rst_async");
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic step(input string tag, input logic [3:0] code, input logic [3:0] bin);
    gray_in = code;
    wait_valid(n);
    chk({tag, "_lat"},  32'(n),             32'd10);
    chk({tag, "_gray"}, 32'(gray_out),      32'(code));
    chk({tag, "_jerr"}, 32'(jump_err),      32'h0);
    chk({tag, "_bin"},  32'(g2b(gray_out)), 32'(bin));
    tick();
    chk({tag, "_pulse1"}, 32'(valid), 32'h0);
    tick();
  endtask

  initial begin
    // 1: held in reset with a nonzero input
    repeat (3) begin
      tick();
      chk_clear("reset");
    end
    rst = 1'b0;
    wait_valid(n);
    chk("rel_lat",    32'(n),        32'd10);
    chk("rel_gray",   32'(gray_out), 32'hb);
    chk("rel_locked", 32'(locked),   32'h1);
    chk("rel_jerr",   32'(jump_err), 32'h0);
    tick();
    chk("rel_pulse1", 32'(valid), 32'h0);

    // 2: acquire 0110
    gray_in = 4'b0110;
    do_reset();
    wait_valid(n);
    chk("acq_lat",    32'(n),        32'd10);
    chk("acq_gray",   32'(gray_out), 32'h6);
    chk("acq_locked", 32'(locked),   32'h1);
    chk("acq_jerr",   32'(jump_err), 32'h0);
    tick();
    chk("acq_pulse1", 32'(valid), 32'h0);

    // 3: legal walk; 0000 matches the reset candidate so it qualifies after 8 edges
    gray_in = 4'b0000;
    do_reset();
    wait_valid(n);
    chk("walk0_lat",  32'(n),        32'd8);
    chk("walk0_gray", 32'(gray_out), 32'h0);
    tick();
    tick();
    step("walk1", 4'b0001, 4'd1);
    step("walk2", 4'b0011, 4'd2);
    step("walk3", 4'b0010, 4'd3);

    // 4: glitch shorter than the hold window, then a real change
    step("back2", 4'b0011, 4'd2);
    gray_in = 4'b0111;
    repeat (5) tick();
    gray_in = 4'b0011;
    quiet(20, p);
    chk("glitch_pulses", 32'(p),        32'd0);
    chk("glitch_gray",   32'(gray_out), 32'h3);
    step("glitch_hold", 4'b0111, 4'd5);

    // 5: multi-bit jump
    gray_in = 4'b0000;
    do_reset();
    wait_valid(n);
    tick();
    gray_in = 4'b1111;
    wait_valid(n);
    chk("jump_lat",    32'(n),        32'd10);
    chk("jump_jerr",   32'(jump_err), 32'h1);
    chk("jump_gray",   32'(gray_out), 32'hf);
    chk("jump_locked", 32'(locked),   32'h1);
    tick();
    chk("jump_pulse1", 32'({valid, jump_err}), 32'h0);

    // Input toggling every cycle, then settling on the held code
    repeat (15) begin
      gray_in = 4'b1110;
      tick();
      gray_in = 4'b1111;
      tick();
    end
    quiet(20, p);
    chk("toggle_pulses", 32'(p),        32'd0);
    chk("toggle_gray",   32'(gray_out), 32'hf);
    chk("toggle_locked", 32'(locked),   32'h1);

    // 6: reset mid-qualification
    gray_in = 4'b1011;
    repeat (4) tick();
    do_reset();
    wait_valid(n);
    chk("reacq_lat",  32'(n),        32'd10);
    chk("reacq_gray", 32'(gray_out), 32'hb);
    chk("reacq_jerr", 32'(jump_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
